uart_cmd_ctrl: RTL and testbench

Command sequencer between the UART receiver and the character buffer of the VGA text pipeline. It collects framed command packets from the received byte stream, validates them, and issues write or fill transactions to the character buffer write port under a ready handshake. Malformed, stalled or out-of-range packets are discarded and flagged.

---
 rtl/uart_cmd_ctrl.sv | 152 +++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: turns framed UART command packets into character buffer write/fill transactions.
// Define UART_CMD_CHECKSUM_EN to require a trailing XOR checksum byte (CHK) on each packet.
module uart_cmd_ctrl #(
  parameter int         ADDR_WIDTH     = 12,
  parameter int         BUF_DEPTH      = 2400,
  parameter int         TIMEOUT_CYCLES = 108000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  mem_ready_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [7:0]            mem_data_o,
  output logic                  busy_o,
  output logic                  cmd_done_o,
  output logic                  err_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(BUF_DEPTH - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_F = 8'h46;
  typedef enum logic [2:0] {S_SYNC, S_CMD, S_ADDRH, S_ADDRL, S_DATA, S_CHK, S_WR, S_FILL} state_t;
  state_t state_q, state_d;
  logic rx_prev_q, rx_prev_d, we_q, we_d, done_q, done_d, err_q, err_d;
  logic [7:0] cmd_q, cmd_d, addrh_q, addrh_d, addrl_q, addrl_d, data_q, data_d, wdata_q, wdata_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, pkt_addr;
  logic byte_stb, exec, cmd_ok, fin, chk_ok;
  logic [7:0] fin_data;
  assign byte_stb = rx_valid_i & ~rx_prev_q;
  assign exec = state_q inside {S_WR, S_FILL};
  assign cmd_ok = rx_data_i inside {CMD_W, CMD_F};
  assign pkt_addr = ADDR_WIDTH'({addrh_q, addrl_q});
`ifdef UART_CMD_CHECKSUM_EN
  assign fin_data = data_q;
  assign chk_ok = rx_data_i == (cmd_q ^ addrh_q ^ addrl_q ^ data_q);
`else
  assign fin_data = rx_data_i;
  assign chk_ok = 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    rx_prev_d = rx_valid_i;
    cmd_d = cmd_q;
    addrh_d = addrh_q;
    addrl_d = addrl_q;
    data_d = data_q;
    tmo_d = '0;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    done_d = 1'b0;
    err_d = 1'b0;
    fin = 1'b0;
    // an arriving byte always beats an expiring timeout
    if (!exec && state_q != S_SYNC && !byte_stb) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_q == TMO_LAST) begin
        tmo_d = '0;
        err_d = 1'b1;
        state_d = S_SYNC;
      end
    end
    case (state_q)
      S_SYNC: if (byte_stb && rx_data_i == SYNC_BYTE) state_d = S_CMD;
      S_CMD: if (byte_stb) begin
        cmd_d = rx_data_i;
        err_d = !cmd_ok;
        state_d = cmd_ok ? S_ADDRH : S_SYNC;
      end
      S_ADDRH: if (byte_stb) begin
        addrh_d = rx_data_i;
        state_d = S_ADDRL;
      end
      S_ADDRL: if (byte_stb) begin
        addrl_d = rx_data_i;
        state_d = S_DATA;
      end
      S_DATA: if (byte_stb) begin
        data_d = rx_data_i;
`ifdef UART_CMD_CHECKSUM_EN
        state_d = S_CHK;
`else
        fin = 1'b1;
`endif
      end
      S_CHK: fin = byte_stb;
      S_WR: if (mem_ready_i) begin
        we_d = 1'b0;
        done_d = 1'b1;
        state_d = S_SYNC;
      end
      S_FILL: if (mem_ready_i) begin
        addr_d = addr_q + 1'b1;
        if (addr_q == LAST) begin
          we_d = 1'b0;
          done_d = 1'b1;
          state_d = S_SYNC;
        end
      end
      default: state_d = S_SYNC;
    endcase
    if (fin) begin
      err_d = !chk_ok || pkt_addr > LAST;
      we_d = !err_d;
      addr_d = pkt_addr;
      wdata_d = fin_data;
      state_d = err_d ? S_SYNC : (cmd_q == CMD_W ? S_WR : S_FILL);
    end
    // a byte dropped on the completing cycle stays silent so done and err never coincide
    if (exec && byte_stb && !done_d) err_d = 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_SYNC;
      rx_prev_q <= 1'b1;
      cmd_q <= '0;
      addrh_q <= '0;
      addrl_q <= '0;
      data_q <= '0;
      tmo_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_prev_q <= rx_prev_d;
      cmd_q <= cmd_d;
      addrh_q <= addrh_d;
      addrl_q <= addrl_d;
      data_q <= data_d;
      tmo_q <= tmo_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign mem_we_o = we_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = wdata_q;
  assign busy_o = exec;
  assign cmd_done_o = done_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: vector table, hand-written corner sequences and randomized packets for uart_cmd_ctrl.
module tb_uart_cmd_ctrl;
  localparam int AW = 12;
  localparam int DEPTH = 2400;
  localparam int TMO = 1000;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] CW = 8'h57;
  localparam logic [7:0] CF = 8'h46;
`ifdef UART_CMD_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  typedef struct packed {logic [AW-1:0] a; logic [7:0] d;} wr_t;
  typedef struct {
    logic [7:0] cmd, ah, al, data;
    int nb; bit bad; int rdy_lo;
    int n; logic [AW-1:0] a; int wec; int ed, ee;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, mem_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic mem_we, busy, cmd_done, err;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_data;
  int vectors = 0, miscompares = 0;
  int done_cnt = 0, err_cnt = 0, we_cycles = 0;
  bit rand_rdy = 1'b0;
  logic p_we = 1'b0, p_rdy = 1'b0, p_rst = 1'b1;
  logic [AW-1:0] p_addr = '0;
  logic [7:0] p_data = '0;
  wr_t obs[$];
  vec_t tbl[10];

  uart_cmd_ctrl #(.ADDR_WIDTH(AW), .BUF_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(SYNC)) dut (
    .clk_i(clk), .rst_i(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data), .mem_ready_i(mem_ready),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_data_o(mem_data), .busy_o(busy),
    .cmd_done_o(cmd_done), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // one clock: observe outputs at the falling edge, then move past the rising edge
  task automatic step();
    @(negedge clk);
    if (mem_we && mem_ready) obs.push_back(wr_t'({mem_addr, mem_data}));
    we_cycles += int'(mem_we);
    done_cnt += int'(cmd_done);
    err_cnt += int'(err);
    if (cmd_done || err) check("done_err_exclusive", 32'(cmd_done & err), 0);
    if (p_we && !p_rdy && !p_rst) begin
      check("hold_we", 32'(mem_we), 1);
      check("hold_addr", 32'(mem_addr), 32'(p_addr));
      check("hold_data", 32'(mem_data), 32'(p_data));
    end
    p_we = mem_we;
    p_rdy = mem_ready;
    p_rst = rst;
    p_addr = mem_addr;
    p_data = mem_data;
    @(posedge clk);
    #1;
    if (rand_rdy) mem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    rx_data = b;
    rx_valid = 1'b1;
    repeat (hold) step();
    rx_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic send_pkt(input logic [7:0] cmd, ah, al, d, input int nb, input bit bad,
                          input int hold, input int gap);
    logic [7:0] q[$];
    q = {SYNC, cmd};
    if (nb > 2) begin
      q.push_back(ah);
      q.push_back(al);
      q.push_back(d);
      if (CHK_EN) q.push_back(cmd ^ ah ^ al ^ d ^ (bad ? 8'h5A : 8'h00));
    end
    foreach (q[i]) send_byte(q[i], hold, (i == q.size() - 1) ? 0 : gap);
  endtask

  task automatic wait_evt(input int base, input int budget);
    for (int k = 0; k < budget && done_cnt + err_cnt == base; k++) step();
    repeat (3) step();
  endtask

  task automatic expect_result(input int ob, input int db, input int eb, input int n,
                               input logic [AW-1:0] a, input logic [7:0] d, input int ed, input int ee);
    check("write_count", obs.size() - ob, n);
    for (int i = ob; i < obs.size() && i - ob < n; i++) begin
      check("write_addr", 32'(obs[i].a), 32'(a + AW'(i - ob)));
      check("write_data", 32'(obs[i].d), 32'(d));
    end
    check("done_pulses", done_cnt - db, ed);
    check("err_pulses", err_cnt - eb, ee);
  endtask

  initial begin
    int ob, db, eb, wb, k, r, nb, n, ea;
    logic [7:0] cmd, d, g;
    logic [15:0] a16;
    bit bad, e;
    tbl[0] = '{CW, 8'h00, 8'h05, 8'h41, 5, 1'b0, 0, 1, 12'd5, 1, 1, 0};
    tbl[1] = '{CW, 8'h00, 8'h05, 8'h41, 5, 1'b0, 10, 1, 12'd5, 11, 1, 0};
    tbl[2] = '{CF, 8'h09, 8'h5C, 8'h20, 5, 1'b0, 0, 4, 12'd2396, 4, 1, 0};
    tbl[3] = '{CF, 8'h09, 8'h60, 8'h20, 5, 1'b0, 0, 0, 12'd0, 0, 0, 1};
    tbl[4] = '{8'h99, 8'h00, 8'h00, 8'h00, 2, 1'b0, 0, 0, 12'd0, 0, 0, 1};
    tbl[5] = '{CW, 8'hF0, 8'h05, 8'h7E, 5, 1'b0, 0, 1, 12'd5, 1, 1, 0};
    tbl[6] = '{CW, 8'h09, 8'h5F, 8'h33, 5, 1'b0, 0, 1, 12'd2399, 1, 1, 0};
    tbl[7] = '{CF, 8'h09, 8'h5F, 8'h44, 5, 1'b0, 3, 1, 12'd2399, 4, 1, 0};
    tbl[8] = '{CW, 8'h09, 8'h60, 8'h11, 5, 1'b0, 0, 0, 12'd0, 0, 0, 1};
    tbl[9] = '{CW, 8'h00, 8'h05, 8'h41, 5, 1'b1, 0, CHK_EN ? 0 : 1, 12'd5, CHK_EN ? 0 : 1,
               CHK_EN ? 0 : 1, CHK_EN ? 1 : 0};
    // reset with rx_valid already high: the held level must not count as a byte
    rx_valid = 1'b1;
    rx_data = SYNC;
    repeat (3) step();
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_data", 32'(mem_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(cmd_done), 0);
    check("rst_err", 32'(err), 0);
    rst = 1'b0;
    repeat (20) step();
    rx_valid = 1'b0;
    step();
    mem_ready = 1'b1;
    ob = obs.size(); db = done_cnt; eb = err_cnt;
    send_pkt(CW, 8'h00, 8'h05, 8'h41, 5, 1'b0, 500, 3);
    wait_evt(db + eb, 100);
    expect_result(ob, db, eb, 1, 12'd5, 8'h41, 1, 0);
    foreach (tbl[i]) begin
      ob = obs.size(); db = done_cnt; eb = err_cnt; wb = we_cycles;
      mem_ready = tbl[i].rdy_lo == 0;
      send_pkt(tbl[i].cmd, tbl[i].ah, tbl[i].al, tbl[i].data, tbl[i].nb, tbl[i].bad, 1, 2);
      repeat (tbl[i].rdy_lo) step();
      mem_ready = 1'b1;
      wait_evt(db + eb, 100);
      expect_result(ob, db, eb, tbl[i].n, tbl[i].a, tbl[i].data, tbl[i].ed, tbl[i].ee);
      check("we_cycles", we_cycles - wb, tbl[i].wec);
    end
    // timeout: error lands exactly TMO+1 observed cycles after the last byte is taken
    ob = obs.size(); db = done_cnt; eb = err_cnt;
    send_byte(SYNC, 1, 1);
    send_byte(CW, 1, 0);
    k = 0;
    while (err_cnt == eb && k < TMO + 50) begin
      step();
      k++;
    end
    check("timeout_latency", k, TMO + 1);
    repeat (3) step();
    expect_result(ob, db, eb, 0, 12'd0, 8'h00, 0, 1);
    // a byte arriving on the last allowed cycle beats the timeout
    ob = obs.size(); db = done_cnt; eb = err_cnt;
    send_pkt(CW, 8'h00, 8'h07, 8'h62, 5, 1'b0, 1, TMO - 1);
    wait_evt(db + eb, 100);
    expect_result(ob, db, eb, 1, 12'd7, 8'h62, 1, 0);
    // byte edge during a fill is dropped with err; fill still finishes
    ob = obs.size(); db = done_cnt; eb = err_cnt;
    send_pkt(CF, 8'h09, 8'h56, 8'h2E, 5, 1'b0, 1, 1);
    repeat (3) step();
    check("busy_in_fill", 32'(busy), 1);
    send_byte(8'h33, 1, 0);
    wait_evt(db + eb, 100);
    wait_evt(db + eb + 1, 100);
    expect_result(ob, db, eb, 10, 12'd2390, 8'h2E, 1, 1);
    check("busy_after_fill", 32'(busy), 0);
    // reset in the middle of a long fill
    send_pkt(CF, 8'h00, 8'h00, 8'h55, 5, 1'b0, 1, 1);
    repeat (50) step();
    db = done_cnt; eb = err_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_we", 32'(mem_we), 0);
    check("midrst_busy", 32'(busy), 0);
    ob = obs.size();
    repeat (20) step();
    expect_result(ob, db, eb, 0, 12'd0, 8'h00, 0, 0);
    // randomized packets against a rule-level model
    rand_rdy = 1'b1;
    for (int p = 0; p < 40; p++) begin
      r = $urandom_range(0, 9);
      nb = 5;
      bad = 1'b0;
      d = 8'($urandom);
      cmd = CW;
      a16 = 16'($urandom);
      if (r == 4 || r == 5) begin
        cmd = CF;
        a16 = {4'($urandom), 12'(DEPTH - 1 - $urandom_range(0, 24))};
      end else if (r == 6) begin
        cmd = 8'($urandom);
        if (cmd == CW || cmd == CF) cmd = 8'h00;
        nb = 2;
      end else if (r == 7) begin
        bad = 1'b1;
        a16 = 16'($urandom_range(0, DEPTH - 1));
      end else if (r == 8) begin
        cmd = CF;
        a16 = {4'($urandom), 12'($urandom_range(DEPTH, 4095))};
      end else if (r == 9) begin
        a16 = 16'($urandom_range(DEPTH - 1, DEPTH));
      end
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom);
        if (g == SYNC) g = 8'h00;
        send_byte(g, 1, 1);
      end
      ob = obs.size(); db = done_cnt; eb = err_cnt;
      send_pkt(cmd, a16[15:8], a16[7:0], d, nb, bad, $urandom_range(1, 4), $urandom_range(1, 4));
      ea = int'(a16) % (1 << AW);
      e = !(cmd == CW || cmd == CF) || (CHK_EN && bad) || ea >= DEPTH;
      n = e ? 0 : (cmd == CW ? 1 : DEPTH - ea);
      wait_evt(db + eb, 600);
      expect_result(ob, db, eb, n, AW'(ea), d, e ? 0 : 1, e ? 1 : 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
